arb_rr2: RTL

- DUT-side two-requester round-robin arbiter; it drives the grant half of the request/grant handshake whose testbench side drives request and reset.
- Samples request[1:0] on posedge clk and returns a registered, one-hot-or-zero grant[1:0].
- Bounded-hold preemption: an owner cannot starve the other requester beyond MAX_HOLD cycles.
- Sits between requesting agents and a shared resource; its ports connect straight to the arbiter interface signals.

---
 rtl/arb_rr2.sv | 107 ++++++++++
 1 files changed

// File: rtl/arb_rr2.sv
// Two-requester round-robin arbiter with bounded-hold preemption.
// Grant, busy and preempt are all registered; nothing combinational reaches the outputs.
module arb_rr2 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] request,
    output logic [1:0] grant,
    output logic       busy,
    output logic       preempt
);

    localparam int unsigned CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic        PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_G0   = 2'd1;
    localparam logic [1:0] ST_G1   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             last_owner_q, last_owner_d;
    logic             preempt_d;
    logic [1:0]       grant_d;

    // Next-state, hold counter, fairness pointer and preemption flag.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        last_owner_d = last_owner_q;
        preempt_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                unique case (request)
                    2'b01:   state_d = ST_G0;
                    2'b10:   state_d = ST_G1;
                    2'b11:   state_d = last_owner_q ? ST_G0 : ST_G1;
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_G0: begin
                if (!request[0]) begin
                    last_owner_d = 1'b0;
                    state_d      = request[1] ? ST_G1 : ST_IDLE;
                end else if (request[1] && PREEMPT_EN && (hold_cnt_q >= HOLD_LAST)) begin
                    last_owner_d = 1'b0;
                    state_d      = ST_G1;
                    preempt_d    = 1'b1;
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            ST_G1: begin
                if (!request[1]) begin
                    last_owner_d = 1'b1;
                    state_d      = request[0] ? ST_G0 : ST_IDLE;
                end else if (request[0] && PREEMPT_EN && (hold_cnt_q >= HOLD_LAST)) begin
                    last_owner_d = 1'b1;
                    state_d      = ST_G0;
                    preempt_d    = 1'b1;
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh grant always starts its hold window from zero.
        if (state_d != state_q) begin
            hold_cnt_d = '0;
        end
    end

    // Grant pattern for the upcoming state, registered below.
    always_comb begin
        grant_d = 2'b00;
        case (state_d)
            ST_G0:   grant_d = 2'b01;
            ST_G1:   grant_d = 2'b10;
            default: grant_d = 2'b00;
        endcase
    end

    // State and output registers; reset parks the pointer on requester 1 so ties favour 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            hold_cnt_q   <= '0;
            last_owner_q <= 1'b1;
            grant        <= 2'b00;
            busy         <= 1'b0;
            preempt      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            last_owner_q <= last_owner_d;
            grant        <= grant_d;
            busy         <= |grant_d;
            preempt      <= preempt_d;
        end
    end

endmodule
